stk_pipe_ad: RTL and testbench
==============================

STK_PIPE_AD -- requirements
Module: stk_pipe_ad

Interface
REQ-001 SHALL have parameter CTXT_N, default 4, number of logical stack contexts (power of 2).
REQ-002 SHALL have parameter DATA_W, default 32, command payload width.
REQ-003 SHALL have parameter CNT_W, default 8, per-context occupancy counter width; context capacity is 2^CNT_W-1.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port arst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_cmd_vld, input, 1, command valid.
REQ-007 SHALL have port i_cmd_op, input, 1, 1=push, 0=pop.
REQ-008 SHALL have port i_cmd_ctxt, input, $clog2(CTXT_N), target context.
REQ-009 SHALL have port i_cmd_dat, input, DATA_W, push payload (ignored for pop).
REQ-010 SHALL have port o_cmd_rdy, output, 1, command accepted when i_cmd_vld & o_cmd_rdy.
REQ-011 SHALL have port o_ad_alloc, output, 1, descriptor allocation strobe to allocator.
REQ-012 SHALL have port i_ad_empty_r, input, 1, allocator has no free descriptor.
REQ-013 SHALL have port i_ad_busy_r, input, 1, allocator initialising.
REQ-014 SHALL have port i_lk_stall, input, 1, lookup stage cannot accept this cycle.
REQ-015 SHALL have ports o_lk_vld_r (1), o_lk_op_r (1), o_lk_ctxt_r ($clog2(CTXT_N)), o_lk_dat_r (DATA_W), o_lk_err_r (1), outputs, registered lookup-stage command.

Function
REQ-016 SHALL implement FSM states INIT and RUN; INIT -> RUN on first cycle i_ad_busy_r=0 seen in INIT; RUN is terminal until reset.
REQ-017 SHALL hold o_cmd_rdy=0 and o_ad_alloc=0 in INIT.
REQ-018 SHALL hold one admission register (AD slot: vld, op, ctxt, dat).
REQ-019 SHALL drive o_cmd_rdy = RUN & (~ad_vld | issue), combinationally; accept and issue in same cycle permitted.
REQ-020 SHALL define issue = ad_vld & ~i_lk_stall.
REQ-021 SHALL classify on issue: push error if i_ad_empty_r=1 or cnt[ctxt]=2^CNT_W-1; pop error if cnt[ctxt]=0; otherwise OK.
REQ-022 SHALL assert o_ad_alloc = issue & op=push & ~error, combinationally, exactly one cycle per successful push.
REQ-023 SHALL on OK push increment cnt[ctxt]; on OK pop decrement; on error leave counters unchanged.
REQ-024 SHALL on issue load o_lk_* from AD slot with o_lk_vld_r=1 and o_lk_err_r=classification, so allocator pointer (one cycle after o_ad_alloc) aligns with o_lk_vld_r.
REQ-025 SHALL set o_lk_vld_r=0 in any cycle without issue; o_lk_op_r/ctxt/dat/err_r hold value when o_lk_vld_r=0.
REQ-026 SHALL, while i_lk_stall=1, hold AD slot contents unchanged and issue nothing.
REQ-027 SHALL maintain order: commands leave on o_lk_* in acceptance order, no drops, no duplicates.
REQ-028 SHALL never assert o_ad_alloc when i_ad_empty_r=1.

Reset
REQ-029 SHALL on arst asynchronously force state=INIT, ad_vld=0, all cnt=0, o_lk_vld_r=0, o_lk_op_r=0, o_lk_ctxt_r=0, o_lk_dat_r=0, o_lk_err_r=0; o_cmd_rdy=0, o_ad_alloc=0.
REQ-030 SHALL discard an in-flight AD command on reset mid-operation; no alloc issued for it after deassertion.

Verification
REQ-031 SHALL cover: reset, i_ad_busy_r=1 for 10 cycles with i_cmd_vld=1 -> o_cmd_rdy=0 throughout; RUN entered cycle after busy drops; first push issued with o_ad_alloc=1 once.
REQ-032 SHALL cover: back-to-back pushes ctxt 0 (dat 0x11,0x22,0x33), no stall -> o_ad_alloc=1 three consecutive cycles, o_lk_dat_r 0x11,0x22,0x33 in order, cnt[0]=3.
REQ-033 SHALL cover: pop ctxt 2 at cnt=0 -> o_lk_err_r=1, o_ad_alloc=0, cnt[2] stays 0; push with i_ad_empty_r=1 -> o_lk_err_r=1, no alloc.
REQ-034 SHALL cover: CNT_W=2, four pushes ctxt 1 -> first three OK (cnt=3), fourth o_lk_err_r=1; then pop -> cnt=2.
REQ-035 SHALL cover: i_lk_stall=1 for 5 cycles with AD occupied -> o_cmd_rdy=0, AD unchanged, o_lk_vld_r=0; on release command issues next cycle unchanged.
REQ-036 SHALL cover: arst asserted while AD holds a push -> no o_ad_alloc after release; all counters read 0 (one pop per context yields error).

Source files
------------

// File: rtl/stk_pipe_ad.sv
// Multi-context stack admission stage: single-entry admission slot feeding a registered
// lookup stage, with per-context occupancy tracking and descriptor-allocation strobes.
module stk_pipe_ad #(
   parameter int CTXT_N = 4,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8,
   localparam int CTXT_W = (CTXT_N > 1) ? $clog2(CTXT_N) : 1
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              i_cmd_vld,
   input  logic              i_cmd_op,
   input  logic [CTXT_W-1:0] i_cmd_ctxt,
   input  logic [DATA_W-1:0] i_cmd_dat,
   output logic              o_cmd_rdy,
   output logic              o_ad_alloc,
   input  logic              i_ad_empty_r,
   input  logic              i_ad_busy_r,
   input  logic              i_lk_stall,
   output logic              o_lk_vld_r,
   output logic              o_lk_op_r,
   output logic [CTXT_W-1:0] o_lk_ctxt_r,
   output logic [DATA_W-1:0] o_lk_dat_r,
   output logic              o_lk_err_r
);

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic                ad_vld_q, ad_vld_d;
   logic                ad_op_q, ad_op_d;
   logic [CTXT_W-1:0]   ad_ctxt_q, ad_ctxt_d;
   logic [DATA_W-1:0]   ad_dat_q, ad_dat_d;
   logic [CNT_W-1:0]    cnt_q [CTXT_N];

   logic                run_s;
   logic                issue_s;
   logic                accept_s;
   logic                err_s;
   logic [CNT_W-1:0]    cur_cnt_s;

   // Handshake, issue and error classification for the command in the admission slot
   always_comb begin
      run_s     = (state_q == ST_RUN);
      issue_s   = ad_vld_q & ~i_lk_stall;
      o_cmd_rdy = run_s & (~ad_vld_q | issue_s);
      accept_s  = i_cmd_vld & o_cmd_rdy;
      cur_cnt_s = cnt_q[ad_ctxt_q];
      if (ad_op_q) begin
         err_s = i_ad_empty_r | (cur_cnt_s == CNT_MAX);
      end else begin
         err_s = (cur_cnt_s == CNT_ZERO);
      end
      o_ad_alloc = issue_s & ad_op_q & ~err_s;
   end

   // Next state: leave INIT once the allocator has finished initialising
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: begin
            if (!i_ad_busy_r) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_INIT;
            end
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   // Admission slot next value: a new accept overwrites, a bare issue empties it
   always_comb begin
      ad_vld_d  = ad_vld_q;
      ad_op_d   = ad_op_q;
      ad_ctxt_d = ad_ctxt_q;
      ad_dat_d  = ad_dat_q;
      if (accept_s) begin
         ad_vld_d  = 1'b1;
         ad_op_d   = i_cmd_op;
         ad_ctxt_d = i_cmd_ctxt;
         ad_dat_d  = i_cmd_dat;
      end else if (issue_s) begin
         ad_vld_d  = 1'b0;
      end else begin
         ad_vld_d  = ad_vld_q;
      end
   end

   // FSM state and admission slot registers
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q   <= ST_INIT;
         ad_vld_q  <= 1'b0;
         ad_op_q   <= 1'b0;
         ad_ctxt_q <= {CTXT_W{1'b0}};
         ad_dat_q  <= {DATA_W{1'b0}};
      end else begin
         state_q   <= state_d;
         ad_vld_q  <= ad_vld_d;
         ad_op_q   <= ad_op_d;
         ad_ctxt_q <= ad_ctxt_d;
         ad_dat_q  <= ad_dat_d;
      end
   end

   // Per-context occupancy; errored commands leave the counts untouched
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < CTXT_N; i++) begin
            cnt_q[i] <= CNT_ZERO;
         end
      end else if (issue_s && !err_s) begin
         if (ad_op_q) begin
            cnt_q[ad_ctxt_q] <= cur_cnt_s + CNT_ONE;
         end else begin
            cnt_q[ad_ctxt_q] <= cur_cnt_s - CNT_ONE;
         end
      end
   end

   // Lookup-stage register: valid for one cycle per issue, payload held otherwise
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         o_lk_vld_r  <= 1'b0;
         o_lk_op_r   <= 1'b0;
         o_lk_ctxt_r <= {CTXT_W{1'b0}};
         o_lk_dat_r  <= {DATA_W{1'b0}};
         o_lk_err_r  <= 1'b0;
      end else if (issue_s) begin
         o_lk_vld_r  <= 1'b1;
         o_lk_op_r   <= ad_op_q;
         o_lk_ctxt_r <= ad_ctxt_q;
         o_lk_dat_r  <= ad_dat_q;
         o_lk_err_r  <= err_s;
      end else begin
         o_lk_vld_r  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stk_pipe_ad.sv
// Scoreboard bench for stk_pipe_ad: directed commands queue their expected lookup-stage
// result; a negedge monitor pops and compares each o_lk_vld_r beat and its alloc strobe.
module tb_stk_pipe_ad;
   localparam int CTXT_N = 4;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 2;
   localparam int CW     = 2;

   logic              clk = 1'b0;
   logic              arst = 1'b1;
   logic              i_cmd_vld = 1'b0;
   logic              i_cmd_op = 1'b0;
   logic [CW-1:0]     i_cmd_ctxt = '0;
   logic [DATA_W-1:0] i_cmd_dat = '0;
   logic              o_cmd_rdy, o_ad_alloc;
   logic              i_ad_empty_r = 1'b0;
   logic              i_ad_busy_r = 1'b1;
   logic              i_lk_stall = 1'b0;
   logic              o_lk_vld_r, o_lk_op_r, o_lk_err_r;
   logic [CW-1:0]     o_lk_ctxt_r;
   logic [DATA_W-1:0] o_lk_dat_r;

   typedef struct packed {
      logic              op;
      logic [CW-1:0]     ctxt;
      logic [DATA_W-1:0] dat;
      logic              err;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   alloc_cnt = 0;
   int   alloc_run = 0;
   int   max_run = 0;
   int   base;
   logic prev_alloc = 1'b0;

   stk_pipe_ad #(.CTXT_N(CTXT_N), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .arst(arst),
      .i_cmd_vld(i_cmd_vld), .i_cmd_op(i_cmd_op), .i_cmd_ctxt(i_cmd_ctxt), .i_cmd_dat(i_cmd_dat),
      .o_cmd_rdy(o_cmd_rdy), .o_ad_alloc(o_ad_alloc),
      .i_ad_empty_r(i_ad_empty_r), .i_ad_busy_r(i_ad_busy_r), .i_lk_stall(i_lk_stall),
      .o_lk_vld_r(o_lk_vld_r), .o_lk_op_r(o_lk_op_r), .o_lk_ctxt_r(o_lk_ctxt_r),
      .o_lk_dat_r(o_lk_dat_r), .o_lk_err_r(o_lk_err_r)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every lookup beat must match the oldest expectation; alloc must precede it by one cycle
   always @(negedge clk) begin
      exp_t e;
      if (o_ad_alloc === 1'b1) begin
         alloc_cnt++;
         alloc_run++;
         if (alloc_run > max_run) max_run = alloc_run;
      end else begin
         alloc_run = 0;
      end
      if (o_ad_alloc === 1'b1 && i_ad_empty_r === 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL alloc_while_empty: got alloc=1, expected 0 (t=%0t)", $time);
      end
      if (o_lk_vld_r === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL lk_unexpected: got beat dat=0x%0h, expected none (t=%0t)", o_lk_dat_r, $time);
         end else begin
            e = exp_q.pop_front();
            chk("lk_op", 64'(o_lk_op_r), 64'(e.op));
            chk("lk_ctxt", 64'(o_lk_ctxt_r), 64'(e.ctxt));
            chk("lk_dat", 64'(o_lk_dat_r), 64'(e.dat));
            chk("lk_err", 64'(o_lk_err_r), 64'(e.err));
            chk("lk_alloc_align", 64'(prev_alloc), 64'(e.op & ~e.err));
         end
      end else if (prev_alloc === 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL alloc_no_beat: got alloc without lookup beat, expected beat (t=%0t)", $time);
      end
      prev_alloc = o_ad_alloc;
   end

   // Drive one command (called at posedge+1), wait bounded for acceptance, queue its expectation
   task automatic send(input logic op, input logic [CW-1:0] ctxt,
                       input logic [DATA_W-1:0] dat, input logic err);
      int   t;
      exp_t e;
      i_cmd_vld  = 1'b1;
      i_cmd_op   = op;
      i_cmd_ctxt = ctxt;
      i_cmd_dat  = dat;
      t = 0;
      @(negedge clk);
      while (o_cmd_rdy !== 1'b1 && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (o_cmd_rdy !== 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: got rdy=0 for 50 cycles, expected 1");
      end else begin
         e.op = op; e.ctxt = ctxt; e.dat = dat; e.err = err;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      i_cmd_vld = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs(input string name);
      chk({name, "_rdy"}, 64'(o_cmd_rdy), 64'd0);
      chk({name, "_alloc"}, 64'(o_ad_alloc), 64'd0);
      chk({name, "_lk_vld"}, 64'(o_lk_vld_r), 64'd0);
      chk({name, "_lk_op"}, 64'(o_lk_op_r), 64'd0);
      chk({name, "_lk_ctxt"}, 64'(o_lk_ctxt_r), 64'd0);
      chk({name, "_lk_dat"}, 64'(o_lk_dat_r), 64'd0);
      chk({name, "_lk_err"}, 64'(o_lk_err_r), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values, then INIT holds off commands while the allocator is busy
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outs("reset");
      @(posedge clk); #1;
      arst = 1'b0;
      i_cmd_vld = 1'b1; i_cmd_op = 1'b1; i_cmd_ctxt = 2'd3; i_cmd_dat = 32'hA5;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("init_rdy", 64'(o_cmd_rdy), 64'd0);
         chk("init_alloc", 64'(o_ad_alloc), 64'd0);
      end
      @(posedge clk); #1;
      i_ad_busy_r = 1'b0;
      @(negedge clk);
      chk("init_last_rdy", 64'(o_cmd_rdy), 64'd0);
      @(negedge clk);
      chk("run_rdy", 64'(o_cmd_rdy), 64'd1);
      exp_q.push_back('{op: 1'b1, ctxt: 2'd3, dat: 32'hA5, err: 1'b0});
      @(posedge clk); #1;
      i_cmd_vld = 1'b0;
      drain();
      chk("first_push_allocs", 64'(alloc_cnt), 64'd1);

      // Back-to-back pushes to context 0
      max_run = 0;
      send(1'b1, 2'd0, 32'h11, 1'b0);
      send(1'b1, 2'd0, 32'h22, 1'b0);
      send(1'b1, 2'd0, 32'h33, 1'b0);
      drain();
      chk("b2b_allocs", 64'(alloc_cnt), 64'd4);
      chk("b2b_consecutive", 64'(max_run), 64'd3);

      // Pop of empty context, push while allocator is empty
      send(1'b0, 2'd2, 32'h0, 1'b1);
      i_ad_empty_r = 1'b1;
      send(1'b1, 2'd2, 32'h44, 1'b1);
      drain();
      i_ad_empty_r = 1'b0;
      chk("err_no_alloc", 64'(alloc_cnt), 64'd4);

      // Capacity 3 with CNT_W=2: fourth push errors, pop frees one slot
      send(1'b1, 2'd1, 32'h1, 1'b0);
      send(1'b1, 2'd1, 32'h2, 1'b0);
      send(1'b1, 2'd1, 32'h3, 1'b0);
      send(1'b1, 2'd1, 32'h4, 1'b1);
      send(1'b0, 2'd1, 32'h0, 1'b0);
      send(1'b1, 2'd1, 32'h5, 1'b0);
      send(1'b1, 2'd1, 32'h6, 1'b1);
      drain();
      chk("full_allocs", 64'(alloc_cnt), 64'd8);

      // Stall holds the slot and blocks intake; release issues the held command
      i_lk_stall = 1'b1;
      send(1'b1, 2'd2, 32'h77, 1'b0);
      i_cmd_vld = 1'b1; i_cmd_op = 1'b1; i_cmd_ctxt = 2'd3; i_cmd_dat = 32'h88;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_rdy", 64'(o_cmd_rdy), 64'd0);
         chk("stall_lk_vld", 64'(o_lk_vld_r), 64'd0);
         chk("stall_alloc", 64'(o_ad_alloc), 64'd0);
      end
      @(posedge clk); #1;
      i_lk_stall = 1'b0;
      @(negedge clk);
      chk("release_rdy", 64'(o_cmd_rdy), 64'd1);
      chk("release_alloc", 64'(o_ad_alloc), 64'd1);
      exp_q.push_back('{op: 1'b1, ctxt: 2'd3, dat: 32'h88, err: 1'b0});
      @(posedge clk); #1;
      i_cmd_vld = 1'b0;
      @(negedge clk);
      chk("release_lk_vld", 64'(o_lk_vld_r), 64'd1);
      chk("release_lk_dat", 64'(o_lk_dat_r), 64'h77);
      @(posedge clk); #1;
      drain();
      chk("stall_allocs", 64'(alloc_cnt), 64'd10);

      // Reset with a push parked in the slot: it must vanish and all counts clear
      i_lk_stall = 1'b1;
      i_cmd_vld = 1'b1; i_cmd_op = 1'b1; i_cmd_ctxt = 2'd2; i_cmd_dat = 32'h99;
      @(negedge clk);
      chk("park_rdy", 64'(o_cmd_rdy), 64'd1);
      @(posedge clk); #1;
      i_cmd_vld = 1'b0;
      base = alloc_cnt;
      arst = 1'b1;
      i_lk_stall = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outs("midreset");
      @(posedge clk); #1;
      arst = 1'b0;
      repeat (5) @(negedge clk);
      chk("midreset_no_alloc", 64'(alloc_cnt), 64'(base));
      @(posedge clk); #1;
      for (int c = 0; c < CTXT_N; c++) begin
         send(1'b0, CW'(c), 32'h0, 1'b1);
      end
      drain();
      chk("post_reset_allocs", 64'(alloc_cnt), 64'(base));
      chk("final_queue", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
